pipe_front_ctrl: RTL and testbench
==================================

PIPE_FRONT_CTRL -- requirements
Module: pipe_front_ctrl

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-low (clk, rst_n).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 stall  input  1  load-use bubble request from the hazard unit.
REQ-005 pcwrite  input  1  PC update enable, low = hold PC.
REQ-006 ifwrite  input  1  IF/ID update enable, low = hold IF/ID.
REQ-007 flush  input  1  branch taken in EX; squash IF/ID and ID/EX.
REQ-008 branch_target  input  32  PC loaded on flush.
REQ-009 instr_in  input  32  instruction fetched at pc_out.
REQ-010 ctrl_in  input  9  decoded control: [8]RegDst [7]ALUSrc [6]MemtoReg [5]RegWrite [4]MemRead [3]MemWrite [2]Branch [1:0]ALUOp.
REQ-011 rs_in, rt_in  input  5 each  register fields decoded from if_id_instr.
REQ-012 pc_out  output  32  current fetch address.
REQ-013 if_id_instr, if_id_pc4  output  32 each  IF/ID instruction and PC+4.
REQ-014 if_id_valid  output  1  IF/ID holds a real instruction.
REQ-015 id_ex_ctrl  output  9  ID/EX control bundle, same bit order as ctrl_in.
REQ-016 id_ex_rs, id_ex_rt  output  5 each  ID/EX register fields.
REQ-017 id_ex_memread  output  1  equals id_ex_ctrl[4]; feeds the hazard unit.
REQ-018 id_ex_valid  output  1  ID/EX holds a real instruction.
REQ-019 stall_cnt  output  16  saturating count of inserted bubbles.
REQ-020 proto_err  output  1  sticky handshake-violation flag.

Function
REQ-021 All registers SHALL update on the rising clk edge only; no output SHALL depend combinationally on inputs except id_ex_memread (= id_ex_ctrl[4]).
REQ-022 PC: flush -> branch_target; else pcwrite=1 -> pc_out+4 (mod 2^32, wrap 0xFFFFFFFC -> 0); else hold.
REQ-023 IF/ID: flush -> if_id_instr=0, if_id_pc4=0, if_id_valid=0; else ifwrite=1 -> capture instr_in, pc_out+4, valid=1; else hold all three.
REQ-024 ID/EX: flush=1 or stall=1 -> id_ex_ctrl=0, id_ex_rs=0, id_ex_rt=0, id_ex_valid=0 (bubble); else capture ctrl_in, rs_in, rt_in, valid=if_id_valid.
REQ-025 Latency: one cycle per stage; an instruction at pc_out in cycle N appears in IF/ID at N+1 and ID/EX at N+2 absent stall/flush.
REQ-026 flush SHALL take priority over stall, pcwrite and ifwrite when simultaneous.
REQ-027 stall_cnt SHALL increment by 1 each cycle with stall=1 and flush=0, saturating at 0xFFFF.
REQ-028 proto_err SHALL set when stall=1 and (pcwrite=1 or ifwrite=1) in the same cycle with flush=0, and hold until reset.
REQ-029 On proto_err condition the datapath SHALL still follow REQ-022..024 unchanged.
REQ-030 A stall held for K consecutive cycles SHALL insert exactly K bubbles and hold PC and IF/ID for K cycles.

Reset
REQ-031 rst_n=0 SHALL immediately force pc_out=0, if_id_instr=0, if_id_pc4=0, if_id_valid=0, id_ex_ctrl=0, id_ex_rs=0, id_ex_rt=0, id_ex_valid=0, stall_cnt=0, proto_err=0, independent of clk.
REQ-032 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state; first edge after release fetches from 0.

Verification
REQ-033 Release reset, pcwrite=ifwrite=1, instr_in=0x8C220004 -> pc_out 0,4,8; cycle 2 if_id_instr=0x8C220004, if_id_pc4=4.
REQ-034 ctrl_in=0x0B0, rs_in=1, rt_in=2, one cycle stall=1, pcwrite=ifwrite=0 -> id_ex_ctrl=0, id_ex_valid=0, pc_out and if_id_instr held, stall_cnt=1; next cycle ID/EX captures 0x0B0,1,2.
REQ-035 flush=1, branch_target=0x00000040, stall=1 same cycle -> pc_out=0x40, if_id_valid=0, id_ex_ctrl=0, stall_cnt unchanged.
REQ-036 stall=1 with pcwrite=1 -> proto_err=1, remains 1 after stall drops, cleared only by rst_n=0.
REQ-037 Force stall_cnt to 0xFFFF via 65535 stalls, one more stall -> stays 0xFFFF; pc_out at 0xFFFFFFFC with pcwrite=1 -> 0x00000000.
REQ-038 Assert rst_n=0 between clock edges during a stall -> all outputs zero immediately, before next edge.

Source files
------------

// File: rtl/pipe_front_ctrl.sv
// Front-end pipeline control: PC register, IF/ID and ID/EX stage registers,
// bubble insertion on load-use stalls, squash on taken branch, plus diagnostics.
module pipe_front_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        pcwrite,
   input  logic        ifwrite,
   input  logic        flush,
   input  logic [31:0] branch_target,
   input  logic [31:0] instr_in,
   input  logic [8:0]  ctrl_in,
   input  logic [4:0]  rs_in,
   input  logic [4:0]  rt_in,
   output logic [31:0] pc_out,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic [8:0]  id_ex_ctrl,
   output logic [4:0]  id_ex_rs,
   output logic [4:0]  id_ex_rt,
   output logic        id_ex_memread,
   output logic        id_ex_valid,
   output logic [15:0] stall_cnt,
   output logic        proto_err
);

   localparam int unsigned MEMREAD_BIT = 4;

   logic [31:0] pc_q, pc_d;
   logic [31:0] if_instr_q, if_instr_d;
   logic [31:0] if_pc4_q, if_pc4_d;
   logic        if_valid_q, if_valid_d;
   logic [8:0]  ex_ctrl_q, ex_ctrl_d;
   logic [4:0]  ex_rs_q, ex_rs_d;
   logic [4:0]  ex_rt_q, ex_rt_d;
   logic        ex_valid_q, ex_valid_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        proto_err_q, proto_err_d;

   logic [31:0] pc_plus4;
   logic        bubble;
   logic        stall_bubble;
   logic        handshake_bad;

   // PC+4 wraps naturally at 32 bits (0xFFFFFFFC -> 0).
   assign pc_plus4      = pc_q + 32'd4;
   assign bubble        = flush | stall;
   assign stall_bubble  = stall & ~flush;
   assign handshake_bad = stall & (pcwrite | ifwrite) & ~flush;

   always_comb begin
      pc_d = pc_q;
      if (flush) begin
         pc_d = branch_target;
      end else if (pcwrite) begin
         pc_d = pc_plus4;
      end
   end

   always_comb begin
      if_instr_d = if_instr_q;
      if_pc4_d   = if_pc4_q;
      if_valid_d = if_valid_q;
      if (flush) begin
         if_instr_d = '0;
         if_pc4_d   = '0;
         if_valid_d = 1'b0;
      end else if (ifwrite) begin
         if_instr_d = instr_in;
         if_pc4_d   = pc_plus4;
         if_valid_d = 1'b1;
      end
   end

   // A bubble is an all-zero control bundle; squash and stall look identical downstream.
   always_comb begin
      ex_ctrl_d  = ctrl_in;
      ex_rs_d    = rs_in;
      ex_rt_d    = rt_in;
      ex_valid_d = if_valid_q;
      if (bubble) begin
         ex_ctrl_d  = '0;
         ex_rs_d    = '0;
         ex_rt_d    = '0;
         ex_valid_d = 1'b0;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall_bubble && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      proto_err_d = proto_err_q | handshake_bad;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= '0;
         if_instr_q  <= '0;
         if_pc4_q    <= '0;
         if_valid_q  <= 1'b0;
         ex_ctrl_q   <= '0;
         ex_rs_q     <= '0;
         ex_rt_q     <= '0;
         ex_valid_q  <= 1'b0;
         stall_cnt_q <= '0;
         proto_err_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         if_instr_q  <= if_instr_d;
         if_pc4_q    <= if_pc4_d;
         if_valid_q  <= if_valid_d;
         ex_ctrl_q   <= ex_ctrl_d;
         ex_rs_q     <= ex_rs_d;
         ex_rt_q     <= ex_rt_d;
         ex_valid_q  <= ex_valid_d;
         stall_cnt_q <= stall_cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign pc_out        = pc_q;
   assign if_id_instr   = if_instr_q;
   assign if_id_pc4     = if_pc4_q;
   assign if_id_valid   = if_valid_q;
   assign id_ex_ctrl    = ex_ctrl_q;
   assign id_ex_rs      = ex_rs_q;
   assign id_ex_rt      = ex_rt_q;
   assign id_ex_memread = ex_ctrl_q[MEMREAD_BIT];
   assign id_ex_valid   = ex_valid_q;
   assign stall_cnt     = stall_cnt_q;
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Directed bench for pipe_front_ctrl: each step queues a hand-computed
// snapshot of all outputs; a negedge monitor pops and compares.
module tb_pipe_front_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stall, pcwrite, ifwrite, flush;
   logic [31:0] branch_target, instr_in;
   logic [8:0]  ctrl_in;
   logic [4:0]  rs_in, rt_in;
   logic [31:0] pc_out, if_id_instr, if_id_pc4;
   logic        if_id_valid;
   logic [8:0]  id_ex_ctrl;
   logic [4:0]  id_ex_rs, id_ex_rt;
   logic        id_ex_memread, id_ex_valid;
   logic [15:0] stall_cnt;
   logic        proto_err;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ifi;
      logic [31:0] ifpc4;
      logic        ifv;
      logic [8:0]  ctrl;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        mr;
      logic        exv;
      logic [15:0] scnt;
      logic        perr;
   } snap_t;

   snap_t exp_q[$];
   string tag_q[$];
   int    n_total = 0;
   int    n_pass  = 0;

   pipe_front_ctrl dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .pcwrite(pcwrite), .ifwrite(ifwrite),
      .flush(flush), .branch_target(branch_target), .instr_in(instr_in),
      .ctrl_in(ctrl_in), .rs_in(rs_in), .rt_in(rt_in), .pc_out(pc_out),
      .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
      .id_ex_ctrl(id_ex_ctrl), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt),
      .id_ex_memread(id_ex_memread), .id_ex_valid(id_ex_valid),
      .stall_cnt(stall_cnt), .proto_err(proto_err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, got queue depth %0d required 0", exp_q.size());
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic drive(input logic st, input logic pw, input logic iw, input logic fl,
                        input logic [31:0] bt, input logic [31:0] ins,
                        input logic [8:0] ctl, input logic [4:0] rs, input logic [4:0] rt);
      stall = st; pcwrite = pw; ifwrite = iw; flush = fl;
      branch_target = bt; instr_in = ins; ctrl_in = ctl; rs_in = rs; rt_in = rt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [31:0] pc, input logic [31:0] ifi,
                               input logic [31:0] ifpc4, input logic ifv, input logic [8:0] ctrl,
                               input logic [4:0] rs, input logic [4:0] rt, input logic exv,
                               input logic [15:0] scnt, input logic perr);
      snap_t s;
      s.pc = pc; s.ifi = ifi; s.ifpc4 = ifpc4; s.ifv = ifv; s.ctrl = ctrl;
      s.rs = rs; s.rt = rt; s.mr = ctrl[4]; s.exv = exv; s.scnt = scnt; s.perr = perr;
      exp_q.push_back(s);
      tag_q.push_back(tag);
   endtask

   // scoreboard / monitor
   task automatic chk(input string tag, input string field, input logic [31:0] act,
                      input logic [31:0] req);
      n_total++;
      if (act !== req)
         $display("FAIL %s.%s: got %h required %h", tag, field, act, req);
      else
         n_pass++;
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         snap_t e;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         chk(t, "pc_out",        pc_out,                  e.pc);
         chk(t, "if_id_instr",   if_id_instr,             e.ifi);
         chk(t, "if_id_pc4",     if_id_pc4,               e.ifpc4);
         chk(t, "if_id_valid",   {31'd0, if_id_valid},    {31'd0, e.ifv});
         chk(t, "id_ex_ctrl",    {23'd0, id_ex_ctrl},     {23'd0, e.ctrl});
         chk(t, "id_ex_rs",      {27'd0, id_ex_rs},       {27'd0, e.rs});
         chk(t, "id_ex_rt",      {27'd0, id_ex_rt},       {27'd0, e.rt});
         chk(t, "id_ex_memread", {31'd0, id_ex_memread},  {31'd0, e.mr});
         chk(t, "id_ex_valid",   {31'd0, id_ex_valid},    {31'd0, e.exv});
         chk(t, "stall_cnt",     {16'd0, stall_cnt},      {16'd0, e.scnt});
         chk(t, "proto_err",     {31'd0, proto_err},      {31'd0, e.perr});
      end
   end

   // directed stimulus
   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 0, 32'h0, 32'h0, 9'h0, 5'd0, 5'd0);
      expect_state("reset", 32'h0, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0, 16'd0, 0);
      tick();
      tick();
      rst_n = 1'b1;
      drive(0, 1, 1, 0, 32'h0, 32'h8C220004, 9'h0B0, 5'd1, 5'd2);
      expect_state("release", 32'h0, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0, 16'd0, 0);

      tick();
      expect_state("fetch1", 32'h4, 32'h8C220004, 32'h4, 1, 9'h0B0, 1, 2, 0, 16'd0, 0);
      tick();
      expect_state("fetch2", 32'h8, 32'h8C220004, 32'h8, 1, 9'h0B0, 1, 2, 1, 16'd0, 0);

      drive(1, 0, 0, 0, 32'h0, 32'h8C220004, 9'h0B0, 5'd1, 5'd2);
      tick();
      expect_state("stall1", 32'h8, 32'h8C220004, 32'h8, 1, 9'h0, 0, 0, 0, 16'd1, 0);

      drive(0, 1, 1, 0, 32'h0, 32'h00221820, 9'h0B0, 5'd1, 5'd2);
      tick();
      expect_state("resume", 32'hC, 32'h00221820, 32'hC, 1, 9'h0B0, 1, 2, 1, 16'd1, 0);

      drive(1, 1, 0, 0, 32'h0, 32'h00221820, 9'h0B0, 5'd1, 5'd2);
      tick();
      expect_state("proto_set", 32'h10, 32'h00221820, 32'hC, 1, 9'h0, 0, 0, 0, 16'd2, 1);

      drive(0, 1, 1, 0, 32'h0, 32'h11111111, 9'h003, 5'd3, 5'd4);
      tick();
      expect_state("proto_hold", 32'h14, 32'h11111111, 32'h14, 1, 9'h003, 3, 4, 1, 16'd2, 1);

      drive(1, 1, 1, 1, 32'h40, 32'h11111111, 9'h003, 5'd3, 5'd4);
      tick();
      expect_state("flush_stall", 32'h40, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0, 16'd2, 1);

      drive(0, 1, 1, 0, 32'h0, 32'h22222222, 9'h1FF, 5'd31, 5'd31);
      tick();
      expect_state("post_flush1", 32'h44, 32'h22222222, 32'h44, 1, 9'h1FF, 31, 31, 0, 16'd2, 1);
      tick();
      expect_state("post_flush2", 32'h48, 32'h22222222, 32'h48, 1, 9'h1FF, 31, 31, 1, 16'd2, 1);

      drive(0, 0, 0, 0, 32'h0, 32'h33333333, 9'h0A5, 5'd7, 5'd9);
      tick();
      expect_state("hold", 32'h48, 32'h22222222, 32'h48, 1, 9'h0A5, 7, 9, 1, 16'd2, 1);

      drive(0, 0, 0, 1, 32'h100, 32'h33333333, 9'h0A5, 5'd7, 5'd9);
      tick();
      expect_state("flush_only", 32'h100, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0, 16'd2, 1);

      drive(1, 0, 0, 0, 32'h0, 32'h33333333, 9'h0A5, 5'd7, 5'd9);
      tick();
      expect_state("stall_inv", 32'h100, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0, 16'd3, 1);

      // async reset mid-stall, checked before the next rising edge
      tick();
      rst_n = 1'b0;
      expect_state("async_rst", 32'h0, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0, 16'd0, 0);
      tick();
      rst_n = 1'b1;
      drive(0, 1, 1, 0, 32'h0, 32'hAAAA0000, 9'h010, 5'd5, 5'd6);
      expect_state("rst_release", 32'h0, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0, 16'd0, 0);
      tick();
      expect_state("refetch", 32'h4, 32'hAAAA0000, 32'h4, 1, 9'h010, 5, 6, 0, 16'd0, 0);

      // saturate the bubble counter
      drive(1, 0, 0, 0, 32'h0, 32'hAAAA0000, 9'h010, 5'd5, 5'd6);
      for (int i = 0; i < 65534; i++) tick();
      tick();
      expect_state("sat_reach", 32'h4, 32'hAAAA0000, 32'h4, 1, 9'h0, 0, 0, 0, 16'hFFFF, 0);
      tick();
      expect_state("sat_hold", 32'h4, 32'hAAAA0000, 32'h4, 1, 9'h0, 0, 0, 0, 16'hFFFF, 0);

      // PC wrap
      drive(0, 1, 1, 1, 32'hFFFFFFFC, 32'h12345678, 9'h0, 5'd0, 5'd0);
      tick();
      expect_state("to_top", 32'hFFFFFFFC, 32'h0, 32'h0, 0, 9'h0, 0, 0, 0, 16'hFFFF, 0);
      drive(0, 1, 1, 0, 32'h0, 32'h12345678, 9'h0, 5'd0, 5'd0);
      tick();
      expect_state("wrap", 32'h0, 32'h12345678, 32'h0, 1, 9'h0, 0, 0, 0, 16'hFFFF, 0);

      // drain the scoreboard
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick();
      n_total++;
      if (exp_q.size() != 0)
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      else
         n_pass++;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
